// File: rtl/pipe_mips32.sv
// pipe_mips32: 5-stage MIPS-like pipeline (IF/ID/EX/MEM/WB) with full EX forwarding, 2-cycle branch flush and halt.
// Define PIPE_MIPS32_MUL_EN to build the MUL opcode; otherwise it executes as a NOP and no multiplier exists.
module pipe_mips32 #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] NOP = 32'hf800_0000;
  localparam logic [5:0] OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3, OP_SLT = 6'd4, OP_MUL = 6'd5;
  localparam logic [5:0] OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63;
`ifdef PIPE_MIPS32_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic [31:0] r_fd_ir, r_fd_npc;
  logic [31:0] r_de_ir, r_de_npc, r_de_a, r_de_b, r_de_imm;
  logic [31:0] r_em_ir, r_em_alu, r_em_b;
  logic [31:0] r_mw_ir, r_mw_val;
  logic        r_stop;
  logic [4:0]  w_rs, w_rt, w_ers, w_ert, w_em_dst, w_mw_dst;
  logic        w_em_wr, w_mw_wr, w_take, w_stall;
  logic [31:0] w_id_a, w_id_b, w_a, w_b, w_alu, w_mul;
  logic [5:0]  w_op;

  function automatic logic [4:0] f_dst(input logic [31:0] ir);
    return (ir[31:26] <= OP_MUL) ? ir[15:11] : ir[20:16];
  endfunction

  // Register-writing instructions; a destination of R0 counts as no write so it is never forwarded either.
  function automatic logic f_wr(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    return (f_dst(ir) != 5'd0) && ((op <= OP_SLT) || (op == OP_MUL && MUL_EN) || op == OP_LW
           || (op >= OP_ADDI && op <= OP_SLTI));
  endfunction

  assign halted   = HALTED;
  assign w_em_wr  = f_wr(r_em_ir);
  assign w_mw_wr  = f_wr(r_mw_ir);
  assign w_em_dst = f_dst(r_em_ir);
  assign w_mw_dst = f_dst(r_mw_ir);
  assign w_rs     = r_fd_ir[25:21];
  assign w_rt     = r_fd_ir[20:16];
  assign w_id_a   = (w_rs == 5'd0) ? 32'd0 : (w_mw_wr && w_mw_dst == w_rs) ? r_mw_val : Reg[w_rs];
  assign w_id_b   = (w_rt == 5'd0) ? 32'd0 : (w_mw_wr && w_mw_dst == w_rt) ? r_mw_val : Reg[w_rt];
  assign w_op     = r_de_ir[31:26];
  assign w_ers    = r_de_ir[25:21];
  assign w_ert    = r_de_ir[20:16];
  assign w_a = (w_em_wr && w_em_dst == w_ers) ? r_em_alu : (w_mw_wr && w_mw_dst == w_ers) ? r_mw_val : r_de_a;
  assign w_b = (w_em_wr && w_em_dst == w_ert) ? r_em_alu : (w_mw_wr && w_mw_dst == w_ert) ? r_mw_val : r_de_b;
`ifdef PIPE_MIPS32_MUL_EN
  assign w_mul = w_a * w_b;
`else
  assign w_mul = 32'd0;
`endif
  assign w_take       = (w_op == OP_BEQZ && w_a == 32'd0) || (w_op == OP_BNEQZ && w_a != 32'd0);
  assign TAKEN_BRANCH = w_take;
  // A taken branch in EX flushes a HLT sitting in ID, so the halt must not latch then.
  assign w_stall      = r_stop || (r_fd_ir[31:26] == OP_HLT && !w_take);

  always_comb begin
    w_alu = w_a + w_b;
    case (w_op)
      OP_SUB:                w_alu = w_a - w_b;
      OP_AND:                w_alu = w_a & w_b;
      OP_OR:                 w_alu = w_a | w_b;
      OP_SLT:                w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      OP_MUL:                w_alu = w_mul;
      OP_LW, OP_SW, OP_ADDI: w_alu = w_a + r_de_imm;
      OP_SUBI:               w_alu = w_a - r_de_imm;
      OP_SLTI:               w_alu = {31'd0, $signed(w_a) < $signed(r_de_imm)};
      default:               ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC       <= 32'd0;
      HALTED   <= 1'b0;
      r_stop   <= 1'b0;
      r_fd_ir  <= NOP;
      r_fd_npc <= 32'd0;
      r_de_ir  <= NOP;
      r_de_npc <= 32'd0;
      r_de_a   <= 32'd0;
      r_de_b   <= 32'd0;
      r_de_imm <= 32'd0;
      r_em_ir  <= NOP;
      r_em_alu <= 32'd0;
      r_em_b   <= 32'd0;
      r_mw_ir  <= NOP;
      r_mw_val <= 32'd0;
    end else begin
      r_em_ir  <= r_de_ir;
      r_em_alu <= w_alu;
      r_em_b   <= w_b;
      r_mw_ir  <= r_em_ir;
      r_mw_val <= (r_em_ir[31:26] == OP_LW) ? Mem[r_em_alu[AW-1:0]] : r_em_alu;
      if (r_mw_ir[31:26] == OP_HLT) HALTED <= 1'b1;
      if (w_take) begin
        PC      <= r_de_npc + r_de_imm;
        r_fd_ir <= NOP;
        r_de_ir <= NOP;
      end else begin
        r_de_ir  <= r_fd_ir;
        r_de_npc <= r_fd_npc;
        r_de_a   <= w_id_a;
        r_de_b   <= w_id_b;
        r_de_imm <= {{16{r_fd_ir[15]}}, r_fd_ir[15:0]};
        if (w_stall) begin
          r_fd_ir <= NOP;
          r_stop  <= 1'b1;
        end else begin
          r_fd_ir  <= Mem[PC[AW-1:0]];
          r_fd_npc <= PC + 32'd1;
          PC       <= PC + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) if (r_em_ir[31:26] == OP_SW) Mem[r_em_alu[AW-1:0]] <= r_em_b;

  always_ff @(posedge clk) if (w_mw_wr) Reg[w_mw_dst] <= r_mw_val;
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed programs; expected architectural state is queued per program and checked when halted rises.
module tb_pipe_mips32;
  logic clk, rst, halted;
  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;
  exp_t        q[$];
  logic [31:0] prog[$];
  int          checks = 0, failures = 0, n_done = 0, taken_cnt = 0;
  logic        prev_halt = 1'b0;

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_reg(input string name, input int idx, input logic [31:0] v);
    q.push_back('{name, 0, idx, v});
  endtask

  task automatic exp_mem(input string name, input int idx, input logic [31:0] v);
    q.push_back('{name, 1, idx, v});
  endtask

  task automatic exp_taken(input string name, input int v);
    q.push_back('{name, 2, 0, v});
  endtask

  // Monitor: the DUT's completion signal is the rising halted flag.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    if (rst) taken_cnt = 0;
    else if (dut.TAKEN_BRANCH) taken_cnt++;
    if (halted && !prev_halt) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        act = (e.kind == 0) ? dut.Reg[e.idx] : (e.kind == 1) ? dut.Mem[e.idx] : taken_cnt;
        check(e.name, act, e.exp);
      end
      n_done++;
    end
    prev_halt = halted;
  end

  task automatic begin_test();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic wait_halt(input string name);
    int base;
    base = n_done;
    for (int c = 0; c < 300 && n_done == base; c++) @(negedge clk);
    if (n_done == base) begin
      check({name, "_halt_timeout"}, {31'd0, halted}, 32'd1);
      q.delete();
    end
  endtask

  task automatic run_to_halt(input string name);
    rst = 1'b0;
    wait_halt(name);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("rst_halted_port", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    begin_test();
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    load_prog();
    exp_reg("p1_r1", 1, 32'd10);
    exp_reg("p1_r2", 2, 32'd20);
    exp_reg("p1_r3", 3, 32'd25);
    exp_reg("p1_r4", 4, 32'd30);
    exp_reg("p1_r5", 5, 32'd55);
    exp_taken("p1_taken", 0);
    run_to_halt("p1");
    repeat (5) @(negedge clk);
    check("p1_halted_sticky", {31'd0, halted}, 32'd1);
    check("p1_pc_held", dut.PC, 32'd9);

    begin_test();
    prog = '{32'h28010005, 32'h00211000, 32'h28000005, 32'h00411800, 32'hfc000000};
    load_prog();
    exp_reg("fwd_r1", 1, 32'd5);
    exp_reg("fwd_r2", 2, 32'd10);
    exp_reg("fwd_r3", 3, 32'd15);
    exp_reg("fwd_r0", 0, 32'd0);
    run_to_halt("fwd");

    begin_test();
    dut.Reg[1] = 32'd7;
    prog = '{32'h24010000, 32'h20060000, 32'h1c000000, 32'h00c64000, 32'hfc000000};
    load_prog();
    exp_mem("swlw_mem0", 0, 32'd7);
    exp_reg("swlw_r6", 6, 32'd7);
    exp_reg("swlw_r8", 8, 32'd14);
    run_to_halt("swlw");

    begin_test();
    prog = '{32'h38000002, 32'h280a0001, 32'h280b0002, 32'h280c0003, 32'hfc000000};
    load_prog();
    exp_reg("br_r10", 10, 32'd10);
    exp_reg("br_r11", 11, 32'd11);
    exp_reg("br_r12", 12, 32'd3);
    exp_taken("br_taken", 1);
    run_to_halt("br");

    begin_test();
    dut.Reg[1] = 32'hffffffff;
    dut.Reg[2] = 32'd1;
    prog = '{32'h30290000, 32'h04023800, 32'h10225000, 32'h14645800, 32'hfc000000};
    load_prog();
    exp_reg("sgn_slti", 9, 32'd1);
    exp_reg("sgn_sub", 7, 32'hffffffff);
    exp_reg("sgn_slt", 10, 32'd1);
`ifdef PIPE_MIPS32_MUL_EN
    exp_reg("mul_r11", 11, 32'd12);
`else
    exp_reg("mul_r11", 11, 32'd11);
`endif
    run_to_halt("sgn");

    begin_test();
    prog = '{32'h34000001, 32'h280d0007, 32'h38000002, 32'hfc000000, 32'h1c000000,
             32'h280e0009, 32'hfc000000};
    load_prog();
    exp_reg("race_r13", 13, 32'd7);
    exp_reg("race_r14", 14, 32'd9);
    exp_taken("race_taken", 1);
    run_to_halt("race");

    begin_test();
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    load_prog();
    exp_reg("rr_r1", 1, 32'd10);
    exp_reg("rr_r2", 2, 32'd20);
    exp_reg("rr_r3", 3, 32'd25);
    exp_reg("rr_r4", 4, 32'd30);
    exp_reg("rr_r5", 5, 32'd55);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_pc_async", dut.PC, 32'd0);
    check("rr_halted_async", {31'd0, dut.HALTED}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rr_r3_done", dut.Reg[3], 32'd25);
    check("rr_r4_aborted", dut.Reg[4], 32'd4);
    wait_halt("rr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_mips32.md
PIPE_MIPS32 -- requirements
Module: pipe_mips32

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, unified instruction/data memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port halted  output  1  copy of internal HALTED flag.
REQ-005 SHALL expose internal state with these exact names for hierarchical preload and inspection:
- Reg[0:31], 32-bit register file
- Mem[0:MEM_DEPTH-1], 32-bit word memory
- PC, 32 bits
- HALTED, 1 bit
- TAKEN_BRANCH, 1 bit

Function
REQ-006 SHALL be a 5-stage pipeline IF, ID, EX, MEM, WB, one stage per clk, one instruction issued per cycle, word-addressed PC.
REQ-007 SHALL decode instruction fields as follows:
- opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], sign-extended to 32 bits.
REQ-008 SHALL implement these R-type opcodes, with result written to rd:
- ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1 or 0), MUL 000101.
REQ-009 SHALL implement these I-type opcodes, with result written to rt:
- ADDI 001010, SUBI 001011, SLTI 001100 (signed).
REQ-010 SHALL implement the memory opcodes:
- LW 001000: rt <= Mem[rs+imm].
- SW 001001: Mem[rs+imm] <= rt.
- Address uses the low log2(MEM_DEPTH) bits.
REQ-011 SHALL implement BNEQZ 001101 and BEQZ 001110:
- Test rs against zero in EX.
- If taken, target = (PC of branch + 1) + imm.
REQ-012 SHALL implement HLT 111111; all other opcodes SHALL execute as NOP, with no register or memory write.
REQ-013 SHALL perform all arithmetic modulo 2^32, with no overflow trap; MUL SHALL keep the low 32 bits of the product.
REQ-014 SHALL never modify Reg[0]; writes to R0 SHALL be discarded.
REQ-015 SHALL forward EX/MEM and MEM/WB results to EX operands, so ALU-to-ALU dependencies at any distance need no NOPs.
REQ-016 SHALL make a WB write visible to a same-cycle ID read of that register.
REQ-017 SHALL NOT interlock on load-use; software SHALL place one instruction between LW and its consumer.
REQ-018 On a taken branch in EX:
- PC SHALL load the target.
- The two younger in-flight instructions SHALL become NOPs (2-cycle penalty).
- TAKEN_BRANCH SHALL be 1 for exactly that cycle.
REQ-019 When HLT is in ID:
- IF SHALL stop fetching, PC SHALL hold, and NOPs SHALL be injected.
- Older instructions SHALL complete.
- HALTED SHALL go to 1 when HLT reaches WB and stay 1 until reset.
REQ-020 A taken branch in EX and HLT in ID in the same cycle: the branch SHALL win and the HLT SHALL be flushed.

Reset
REQ-021 While rst=1, SHALL asynchronously clear the following; Reg and Mem SHALL NOT be reset:
- PC=0, HALTED=0, TAKEN_BRANCH=0.
- All pipeline instruction registers set to NOP (no write enable), all other pipeline registers 0.
REQ-022 Reset mid-execution SHALL abort all in-flight instructions without writes; fetch SHALL restart at Mem[0] on the first clk after rst falls.

Configuration
REQ-023 SHALL support macro PIPE_MIPS32_MUL_EN:
- When defined, MUL executes per REQ-008 and REQ-013.
- When undefined, opcode 000101 SHALL execute as NOP and no multiplier SHALL be synthesized.

Verification
REQ-024 Preload Reg[k]=k and this program, then run 40 cycles -> R1=10, R2=20, R3=25, R4=30, R5=55, halted=1:
- Mem[0..8] = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000.
REQ-025 Back-to-back dependency: ADDI R1,R0,5 then ADD R2,R1,R1 then HLT -> R2=10 through forwarding.
REQ-026 SW then LW: SW R1,0(R0) with R1=7, then LW R6,0(R0), NOP, ADD R8,R6,R6 -> Mem[0]=7, R6=7, R8=14.
REQ-027 BEQZ R0 taken over two ADDIs -> neither skipped ADDI writes; TAKEN_BRANCH pulses once; the target instruction executes.
REQ-028 Signed compare: SLTI R9,R1,0 with R1=FFFFFFFF -> R9=1; SUB 0-1 -> FFFFFFFF.
REQ-029 Assert rst mid-program for 1 cycle -> PC=0 and HALTED=0 immediately, with no writes from in-flight instructions; the program reruns to the same final registers.
